// File: rtl/arp_tx_ctrl.sv
// arp_tx_ctrl: schedules ARP reply/request frames ahead of the Ethernet TX path, with retry and address resolution.
module arp_tx_ctrl #(
  parameter int RETRY_CYCLES = 125000000,
  parameter int MAX_TRIES    = 3,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        resolve_req,
  input  logic [31:0] target_ip,
  input  logic        arp_req_rx_valid,
  input  logic [47:0] arp_req_rx_mac,
  input  logic [31:0] arp_req_rx_ip,
  input  logic        arp_rply_rx_valid,
  input  logic [47:0] arp_rply_rx_mac,
  input  logic [31:0] arp_rply_rx_ip,
  input  logic        tx_busy,
  input  logic        arp_data_tx_done,
  output logic        eth_header_arp_tx_start,
  output logic        arp_oper,
  output logic [47:0] mac_d_addr,
  output logic [31:0] ip_d_addr,
  output logic        resolved,
  output logic [47:0] resolved_mac,
  output logic        resolve_fail
);
  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
  state_t state, state_nx;
  logic rply_pend, req_pend, active, tmr_run, go, match, expire;
  logic [47:0] rply_mac;
  logic [31:0] rply_ip, tgt_ip, tmr;
  logic [7:0] gap_cnt;
  logic [3:0] tries;
  always_comb begin
    go = (rply_pend | req_pend) && !tx_busy && gap_cnt == 8'd0;
    match = arp_rply_rx_valid && active && arp_rply_rx_ip == tgt_ip;
    expire = tmr_run && tmr == 32'd0;
    state_nx = state == IDLE  ? (go ? START : IDLE) :
               state == START ? SEND :
               state == SEND  ? (arp_data_tx_done ? GAP : SEND) :
               (gap_cnt <= 8'd1 ? IDLE : GAP);
  end
  assign eth_header_arp_tx_start = state == START;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      rply_pend <= 1'b0;
      req_pend <= 1'b0;
      active <= 1'b0;
      tmr_run <= 1'b0;
      tmr <= '0;
      gap_cnt <= '0;
      tries <= '0;
      rply_mac <= '0;
      rply_ip <= '0;
      tgt_ip <= '0;
      arp_oper <= 1'b0;
      mac_d_addr <= '0;
      ip_d_addr <= '0;
      resolved <= 1'b0;
      resolved_mac <= '0;
      resolve_fail <= 1'b0;
    end else begin
      state <= state_nx;
      resolve_fail <= 1'b0;
      gap_cnt <= (state == SEND && arp_data_tx_done) ? 8'(IFG_CYCLES) :
                 (gap_cnt != 8'd0 ? gap_cnt - 8'd1 : 8'd0);
      // Frame fields are captured on the way into START and held for the whole frame.
      if (state == IDLE && go) begin
        arp_oper <= rply_pend;
        mac_d_addr <= rply_pend ? rply_mac : 48'hFFFF_FFFF_FFFF;
        ip_d_addr <= rply_pend ? rply_ip : tgt_ip;
        if (rply_pend) rply_pend <= 1'b0;
        else begin
          req_pend <= 1'b0;
          tries <= tries + 4'd1;
        end
      end
      if (arp_req_rx_valid) begin
        rply_pend <= 1'b1;
        rply_mac <= arp_req_rx_mac;
        rply_ip <= arp_req_rx_ip;
      end
      if (tmr_run) tmr <= tmr - 32'd1;
      if (expire) begin
        tmr_run <= 1'b0;
        if (tries >= 4'(MAX_TRIES)) begin
          resolve_fail <= 1'b1;
          active <= 1'b0;
        end else req_pend <= 1'b1;
      end
      if (state == SEND && arp_data_tx_done && !arp_oper && active) begin
        tmr <= 32'(RETRY_CYCLES - 1);
        tmr_run <= 1'b1;
      end
      if (match) begin
        resolved <= 1'b1;
        resolved_mac <= arp_rply_rx_mac;
        tmr_run <= 1'b0;
        req_pend <= 1'b0;
        active <= 1'b0;
      end
      // A new resolve request overrides everything above, including a same-cycle match.
      if (resolve_req) begin
        tgt_ip <= target_ip;
        resolved <= 1'b0;
        resolved_mac <= '0;
        tries <= '0;
        req_pend <= 1'b1;
        active <= 1'b1;
        tmr_run <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arp_tx_ctrl.sv
// tb_arp_tx_ctrl: randomized scoreboard bench; stimulus queues expected frames, a monitor pops them on each start pulse.
module tb_arp_tx_ctrl;
  localparam int RETRY = 100, TRIES = 3, IFG = 12;
  typedef struct {logic oper; logic [47:0] mac; logic [31:0] ip;} frame_t;
  logic aclk = 0, aresetn = 0, resolve_req = 0, arp_req_rx_valid = 0, arp_rply_rx_valid = 0;
  logic tx_busy = 0, arp_data_tx_done = 0;
  logic [31:0] target_ip = 0, arp_req_rx_ip = 0, arp_rply_rx_ip = 0, ip_d_addr;
  logic [47:0] arp_req_rx_mac = 0, arp_rply_rx_mac = 0, mac_d_addr, resolved_mac;
  logic eth_header_arp_tx_start, arp_oper, resolved, resolve_fail;
  arp_tx_ctrl #(.RETRY_CYCLES(RETRY), .MAX_TRIES(TRIES), .IFG_CYCLES(IFG)) dut (
    .aclk(aclk), .aresetn(aresetn), .resolve_req(resolve_req), .target_ip(target_ip),
    .arp_req_rx_valid(arp_req_rx_valid), .arp_req_rx_mac(arp_req_rx_mac), .arp_req_rx_ip(arp_req_rx_ip),
    .arp_rply_rx_valid(arp_rply_rx_valid), .arp_rply_rx_mac(arp_rply_rx_mac), .arp_rply_rx_ip(arp_rply_rx_ip),
    .tx_busy(tx_busy), .arp_data_tx_done(arp_data_tx_done),
    .eth_header_arp_tx_start(eth_header_arp_tx_start), .arp_oper(arp_oper), .mac_d_addr(mac_d_addr),
    .ip_d_addr(ip_d_addr), .resolved(resolved), .resolved_mac(resolved_mac), .resolve_fail(resolve_fail)
  );
  always #4 aclk = ~aclk;
  int cyc = 0, tests = 0, fails = 0, n_starts = 0, n_fail = 0, last_done = -1000, start_cyc = 0, fail_cyc = 0;
  bit in_frame = 0, prev_busy = 0;
  logic [80:0] cur;
  frame_t exp_q[$];
  frame_t e;
  always @(posedge aclk) cyc++;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask
  // Monitor: every start pulse must match the oldest expected frame, respect tx_busy and the gap.
  always @(negedge aclk) begin
    if (!aresetn) in_frame = 0;
    else begin
      if (resolve_fail) begin
        n_fail++;
        fail_cyc = cyc;
      end
      if (eth_header_arp_tx_start) begin
        n_starts++;
        start_cyc = cyc;
        chk("start_gated_by_busy", 96'(prev_busy), 96'(0));
        chk("start_after_gap", 96'(cyc - last_done > IFG), 96'(1));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: oper %0d ip %0h, no frame expected (cycle %0d)", arp_oper, ip_d_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("frame_oper", 96'(arp_oper), 96'(e.oper));
          chk("frame_mac", 96'(mac_d_addr), 96'(e.mac));
          chk("frame_ip", 96'(ip_d_addr), 96'(e.ip));
        end
        cur = {arp_oper, mac_d_addr, ip_d_addr};
        in_frame = 1;
      end else if (in_frame) chk("frame_hold", 96'({arp_oper, mac_d_addr, ip_d_addr}), 96'(cur));
      if (in_frame && arp_data_tx_done) begin
        in_frame = 0;
        last_done = cyc;
      end
    end
    prev_busy = tx_busy;
  end
  // TX path model: finishes each frame a random number of cycles after its start.
  initial forever begin
    @(negedge aclk);
    if (aresetn && eth_header_arp_tx_start) begin
      repeat ($urandom_range(3, 15)) @(posedge aclk);
      #1 arp_data_tx_done = 1;
      @(posedge aclk);
      #1 arp_data_tx_done = 0;
    end
  end
  task automatic pulse_req(input logic [47:0] m, input logic [31:0] i);
    arp_req_rx_mac = m;
    arp_req_rx_ip = i;
    arp_req_rx_valid = 1;
    tick(1);
    arp_req_rx_valid = 0;
  endtask
  task automatic pulse_rply(input logic [47:0] m, input logic [31:0] i);
    arp_rply_rx_mac = m;
    arp_rply_rx_ip = i;
    arp_rply_rx_valid = 1;
    tick(1);
    arp_rply_rx_valid = 0;
  endtask
  task automatic resolve(input logic [31:0] t);
    target_ip = t;
    resolve_req = 1;
    exp_q.push_back('{1'b0, 48'hFFFF_FFFF_FFFF, t});
    tick(1);
    resolve_req = 0;
  endtask
  task automatic expect_starts(input int tgt, input int bound, input string name);
    int t = 0;
    while (n_starts < tgt && t < bound) begin
      tick(1);
      t++;
    end
    if (n_starts < tgt) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, %0d starts seen, %0d required", name, n_starts, tgt);
    end
  endtask
  task automatic wait_frame_end(input string name);
    int t = 0;
    while (in_frame && t < 100) begin
      tick(1);
      t++;
    end
    if (in_frame) begin
      tests++;
      fails++;
      $display("FAIL %s: frame still open after 100 cycles, expected done", name);
    end
  endtask
  task automatic wait_quiet(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || in_frame || cyc - last_done <= IFG + 2) && t < 3000) begin
      tick(1);
      t++;
    end
    if (exp_q.size() != 0 || in_frame) begin
      tests++;
      fails++;
      $display("FAIL %s: %0d frames still outstanding, expected 0", name, exp_q.size());
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, 96'(eth_header_arp_tx_start), 96'(0));
    chk({tag, "_oper"}, 96'(arp_oper), 96'(0));
    chk({tag, "_mac"}, 96'(mac_d_addr), 96'(0));
    chk({tag, "_ip"}, 96'(ip_d_addr), 96'(0));
    chk({tag, "_resolved"}, 96'(resolved), 96'(0));
    chk({tag, "_resolved_mac"}, 96'(resolved_mac), 96'(0));
    chk({tag, "_fail"}, 96'(resolve_fail), 96'(0));
  endtask
  initial begin
    logic [63:0] r;
    logic [47:0] m, m2;
    logic [31:0] ip, t;
    int ns, f0, d, b;
    tick(3);
    chk_zero("reset");
    aresetn = 1;
    tick(2);
    exp_q.push_back('{1'b1, 48'h02_00_00_00_00_01, 32'hC0A8_010A});
    pulse_req(48'h02_00_00_00_00_01, 32'hC0A8_010A);
    wait_quiet("reply_basic");
    for (int k = 0; k < 8; k++) begin
      r = {$urandom(), $urandom()};
      m = r[47:0];
      ip = $urandom();
      tx_busy = 1'($urandom_range(0, 1));
      exp_q.push_back('{1'b1, m, ip});
      pulse_req(m, ip);
      tick($urandom_range(0, 6));
      tx_busy = 0;
      wait_quiet("reply_random");
    end
    tx_busy = 1;
    pulse_req(48'h0A0A_0A0A_0A0A, 32'h0A00_0001);
    pulse_req(48'h0B0B_0B0B_0B0B, 32'h0A00_0002);
    exp_q.push_back('{1'b1, 48'h0B0B_0B0B_0B0B, 32'h0A00_0002});
    tick(2);
    tx_busy = 0;
    wait_quiet("reply_overwrite");
    for (int k = 0; k < 5; k++) begin
      r = {$urandom(), $urandom()};
      m = (k == 0) ? 48'h02_00_00_00_00_02 : r[47:0];
      t = (k == 0) ? 32'hC0A8_0114 : $urandom();
      ns = n_starts;
      resolve(t);
      expect_starts(ns + 1, 20, "resolve_start");
      tick($urandom_range(0, 8));
      pulse_rply(~m, t + 32'd1);
      chk("nonmatch_ignored", 96'(resolved), 96'(0));
      pulse_rply(m, t);
      chk("resolved", 96'(resolved), 96'(1));
      chk("resolved_mac", 96'(resolved_mac), 96'(m));
      tick(3 * RETRY);
      wait_quiet("resolve_no_retry");
    end
    ns = n_starts;
    f0 = n_fail;
    d = 0;
    resolve(32'hC0A8_011E);
    exp_q.push_back('{1'b0, 48'hFFFF_FFFF_FFFF, 32'hC0A8_011E});
    exp_q.push_back('{1'b0, 48'hFFFF_FFFF_FFFF, 32'hC0A8_011E});
    for (int k = 0; k < TRIES; k++) begin
      expect_starts(ns + k + 1, 3 * RETRY, "retry_start");
      if (k > 0) chk("retry_spacing", 96'(start_cyc - d >= RETRY && start_cyc - d <= RETRY + 3), 96'(1));
      wait_frame_end("retry_done");
      d = last_done;
    end
    tick(RETRY + 10);
    chk("fail_pulses", 96'(n_fail - f0), 96'(1));
    chk("fail_delay", 96'(fail_cyc - d >= RETRY && fail_cyc - d <= RETRY + 3), 96'(1));
    chk("fail_unresolved", 96'(resolved), 96'(0));
    tick(2 * RETRY);
    chk("fail_pulses_final", 96'(n_fail - f0), 96'(1));
    chk("retry_frame_count", 96'(n_starts - ns), 96'(TRIES));
    wait_quiet("retry");
    ns = n_starts;
    resolve(32'hC0A8_0120);
    expect_starts(ns + 1, 20, "collision_req");
    exp_q.push_back('{1'b1, 48'h02_00_00_00_00_33, 32'hC0A8_0133});
    pulse_req(48'h02_00_00_00_00_33, 32'hC0A8_0133);
    pulse_rply(48'h02_00_00_00_00_20, 32'hC0A8_0120);
    chk("collision_resolved", 96'(resolved), 96'(1));
    wait_quiet("collision");
    chk("collision_frames", 96'(n_starts - ns), 96'(2));
    ns = n_starts;
    tx_busy = 1;
    exp_q.push_back('{1'b1, 48'h02_00_00_00_00_44, 32'hC0A8_0144});
    pulse_req(48'h02_00_00_00_00_44, 32'hC0A8_0144);
    resolve(32'hC0A8_0121);
    tick(3);
    tx_busy = 0;
    expect_starts(ns + 2, 200, "priority_starts");
    tick(1);
    pulse_rply(48'h02_00_00_00_00_21, 32'hC0A8_0121);
    chk("priority_resolved_mac", 96'(resolved_mac), 96'(48'h02_00_00_00_00_21));
    wait_quiet("priority");
    ns = n_starts;
    tx_busy = 1;
    exp_q.push_back('{1'b1, 48'h02_00_00_00_00_55, 32'hC0A8_0155});
    pulse_req(48'h02_00_00_00_00_55, 32'hC0A8_0155);
    tick(49);
    tx_busy = 0;
    b = cyc;
    expect_starts(ns + 1, 20, "busy_start");
    chk("busy_release_start", 96'(start_cyc), 96'(b + 1));
    wait_quiet("busy");
    ns = n_starts;
    resolve(32'hC0A8_0166);
    expect_starts(ns + 1, 20, "reset_req");
    tick(1);
    #2 aresetn = 0;
    #1 chk_zero("midframe_reset");
    exp_q.delete();
    tick(2);
    aresetn = 1;
    tick(2 * RETRY);
    chk("no_start_after_reset", 96'(n_starts - ns), 96'(1));
    pulse_rply(48'h02_00_00_00_00_66, 32'hC0A8_0167);
    tick(2);
    chk("reset_nonmatch", 96'(resolved), 96'(0));
    chk("queue_empty", 96'(exp_q.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, expected completion well before cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/arp_tx_ctrl.md
Name: arp_tx_ctrl

Overview:
- Control stage directly upstream of the Ethernet TX path, on the same clock (gmii_tx_clk domain).
- Decides when ARP frames are sent. Issues the single-cycle eth_header_arp_tx_start pulse together with arp_oper, mac_d_addr and ip_d_addr, then waits for arp_data_tx_done.
- Handles two traffic types: ARP replies to received requests, and ARP requests for a target IP, with timeout/retry. Publishes the resolved destination MAC.

Parameters:
- RETRY_CYCLES, 125000000: cycles to wait for an ARP reply before retransmitting a request (1 s at 125 MHz).
- MAX_TRIES, 3: total request transmissions before reporting failure (range 1..15).
- IFG_CYCLES, 12: minimum idle cycles after arp_data_tx_done before the next start (range 1..255).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- resolve_req  in  1  pulse: start resolution of target_ip
- target_ip  in  32  IP to resolve; sampled on resolve_req
- arp_req_rx_valid  in  1  pulse: received ARP request addressed to us
- arp_req_rx_mac  in  48  sender MAC of the received request
- arp_req_rx_ip  in  32  sender IP of the received request
- arp_rply_rx_valid  in  1  pulse: received ARP reply
- arp_rply_rx_mac  in  48  sender MAC of the received reply
- arp_rply_rx_ip  in  32  sender IP of the received reply
- tx_busy  in  1  IP/UDP frame in progress; no start while high
- arp_data_tx_done  in  1  pulse: ARP payload fully sent
- eth_header_arp_tx_start  out  1  one-cycle start pulse
- arp_oper  out  1  0 = request, 1 = reply
- mac_d_addr  out  48  destination MAC for the frame
- ip_d_addr  out  32  destination IP for the frame
- resolved  out  1  resolved_mac is valid for target_ip
- resolved_mac  out  48  MAC learned from the reply
- resolve_fail  out  1  one-cycle pulse after MAX_TRIES attempts are exhausted

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending flags cleared; gap counter 0 (gap satisfied).
- FSM states: IDLE, START, SEND, GAP.
  - IDLE → START when all of: (rply_pend or req_pend), tx_busy == 0, gap counter == 0.
  - START lasts exactly one cycle. eth_header_arp_tx_start = 1. arp_oper, mac_d_addr and ip_d_addr are driven this cycle and held stable until arp_data_tx_done.
  - SEND → GAP on arp_data_tx_done. Load gap counter with IFG_CYCLES.
  - GAP → IDLE when the gap counter reaches 0.
- Priority: if rply_pend and req_pend are both set in IDLE, the reply is sent first.
- Reply path:
  - arp_req_rx_valid sets rply_pend and latches the sender MAC/IP into a single-entry buffer.
  - A new request arriving before START overwrites the buffer.
  - A new request arriving during START/SEND/GAP is latched and sent next.
  - The reply frame uses arp_oper = 1, mac_d_addr = latched MAC, ip_d_addr = latched IP.
  - rply_pend clears in the START cycle that consumes it.
- Request path:
  - resolve_req latches target_ip, clears resolved and resolved_mac, sets try counter to 0, sets req_pend.
  - The request frame uses arp_oper = 0, mac_d_addr = 48'hFFFFFFFFFFFF, ip_d_addr = target_ip.
  - START increments the try counter and clears req_pend.
  - After arp_data_tx_done, a retry timer loads RETRY_CYCLES-1 and counts down independently of the FSM.
  - Timer expiry with tries < MAX_TRIES: set req_pend.
  - Timer expiry with tries == MAX_TRIES: pulse resolve_fail; resolution ends.
- Reply match:
  - arp_rply_rx_valid with arp_rply_rx_ip == target_ip while resolution is active: set resolved = 1, resolved_mac = arp_rply_rx_mac, stop the timer, clear req_pend.
  - A match during SEND of a request is accepted; no further retries.
  - Non-matching replies are ignored.
- resolve_req while resolution is active restarts it with the new target. A frame already in SEND completes unchanged.
- Reset mid-frame: state returns to IDLE immediately. No start is reissued until a new pending event.
- tx_busy only gates the IDLE → START transition; it has no effect once in START/SEND.

Test Plan:
- Reply: arp_req_rx_valid with MAC 02:00:00:00:00:01, IP 192.168.1.10 → one-cycle start, arp_oper = 1, mac_d/ip_d equal those values; after done, idle for 12 cycles.
- Resolve: resolve_req with target 192.168.1.20 → start with arp_oper = 0, mac_d = FF:FF:FF:FF:FF:FF. Matching reply with MAC 02:..:02 → resolved = 1, resolved_mac = 02:..:02, no retry.
- Retries (RETRY_CYCLES = 100): resolve with no reply → exactly 3 request frames, spaced 100 cycles after each done; resolve_fail pulses once; resolved stays 0.
- Collision and priority: arp_req_rx_valid during SEND of a request → the reply is sent next, after the 12-cycle gap. Both pending in IDLE → reply first.
- tx_busy held high for 50 cycles with a pending reply → no start until the cycle after tx_busy falls.
- Reset asserted during SEND → all outputs 0 asynchronously; after release no start until a new event; a non-matching reply leaves resolved = 0.
